// File: rtl/board_pkg.sv
// Shared types for the game-board memory: cell codes and the controller state encoding.
package board_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] SHIP  = 2'd1;
    localparam logic [1:0] MISS  = 2'd2;
    localparam logic [1:0] HIT   = 2'd3;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        CAS_RD = 2'd2,
        CAS_WR = 2'd3
    } board_mem_state_t;

endpackage

// File: rtl/board_clear_seq.sv
// Raster walker over the in-range board cells; one cell per cycle from (0,0) to (X_SIZE-1,Y_SIZE-1).
module board_clear_seq
    import board_pkg::*;
#(
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic [X_ADDR_WIDTH-1:0] x,
    output logic [Y_ADDR_WIDTH-1:0] y,
    output logic                    last
);

    localparam logic [X_ADDR_WIDTH-1:0] X_LAST = X_ADDR_WIDTH'(X_SIZE - 1);
    localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST = Y_ADDR_WIDTH'(Y_SIZE - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            busy <= 1'b1;
            x    <= '0;
            y    <= '0;
        end else if (busy) begin
            if (last) begin
                busy <= 1'b0;
                x    <= '0;
                y    <= '0;
            end else if (x == X_LAST) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_mem_mp.sv
// Single-clock board memory: N_RD registered read ports, one write port, an atomic
// compare-and-swap port and a self-clearing sequencer that runs after reset or on request.
module board_mem_mp
    import board_pkg::*;
#(
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH   = 2,
    parameter int N_RD         = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_req,
    output logic                           busy,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [X_ADDR_WIDTH-1:0]        wr_x,
    input  logic [Y_ADDR_WIDTH-1:0]        wr_y,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           cas_valid,
    output logic                           cas_ready,
    input  logic [X_ADDR_WIDTH-1:0]        cas_x,
    input  logic [Y_ADDR_WIDTH-1:0]        cas_y,
    input  logic [DATA_WIDTH-1:0]          cas_expect,
    input  logic [DATA_WIDTH-1:0]          cas_new,
    output logic                           cas_done,
    output logic                           cas_ok,
    output logic [DATA_WIDTH-1:0]          cas_old,
    input  logic [N_RD*X_ADDR_WIDTH-1:0]   rd_x,
    input  logic [N_RD*Y_ADDR_WIDTH-1:0]   rd_y,
    output logic [N_RD*DATA_WIDTH-1:0]     rd_data
);

    localparam int AW    = X_ADDR_WIDTH + Y_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    // Full power-of-two array; cells outside the board are never written or returned.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    board_mem_state_t state, next_state;

    logic                    seq_busy, seq_last;
    logic [X_ADDR_WIDTH-1:0] seq_x;
    logic [Y_ADDR_WIDTH-1:0] seq_y;

    logic clear_pend, clear_take;
    logic wr_acc, wr_oor, cas_acc, cas_in_oor, cas_hit;

    logic [AW-1:0]         cas_addr;
    logic [DATA_WIDTH-1:0] cas_exp_q, cas_new_q, cas_rdata;
    logic                  cas_oor_q;

    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    board_clear_seq #(
        .X_SIZE      (X_SIZE),
        .Y_SIZE      (Y_SIZE),
        .X_ADDR_WIDTH(X_ADDR_WIDTH),
        .Y_ADDR_WIDTH(Y_ADDR_WIDTH)
    ) u_clear_seq (
        .clk  (clk),
        .rst  (rst),
        .start(clear_take),
        .busy (seq_busy),
        .x    (seq_x),
        .y    (seq_y),
        .last (seq_last)
    );

    assign wr_oor     = (32'(wr_x) >= X_SIZE) || (32'(wr_y) >= Y_SIZE);
    assign cas_in_oor = (32'(cas_x) >= X_SIZE) || (32'(cas_y) >= Y_SIZE);
    assign clear_take = (state == IDLE) && (clear_req || clear_pend);
    assign wr_acc     = wr_valid && wr_ready;
    assign cas_acc    = cas_valid && cas_ready;
    assign cas_hit    = !cas_oor_q && (cas_rdata == cas_exp_q);

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (seq_busy && seq_last) next_state = IDLE;
            IDLE: begin
                if (clear_take)   next_state = CLEAR;
                else if (cas_acc) next_state = CAS_RD;
            end
            CAS_RD:  next_state = CAS_WR;
            CAS_WR:  next_state = IDLE;
            default: next_state = CLEAR;
        endcase
    end

    always_comb begin
        busy      = (state == CLEAR);
        cas_ready = (state == IDLE) && !clear_take;
        wr_ready  = (state == IDLE) && !clear_take && !cas_valid;
        cas_done  = (state == CAS_WR);
        cas_ok    = (state == CAS_WR) && cas_hit;
        cas_old   = CLEAR_VALUE;
        if (state == CAS_WR && !cas_oor_q) cas_old = cas_rdata;
    end

    // A clear requested mid-CAS waits until the CAS has finished.
    always_ff @(posedge clk) begin
        if (rst)                                                  clear_pend <= 1'b0;
        else if (clear_take)                                      clear_pend <= 1'b0;
        else if (clear_req && (state == CAS_RD || state == CAS_WR)) clear_pend <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (cas_acc) begin
            cas_addr  <= {cas_y, cas_x};
            cas_exp_q <= cas_expect;
            cas_new_q <= cas_new;
            cas_oor_q <= cas_in_oor;
        end
        if (state == CAS_RD) cas_rdata <= mem[cas_addr];
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = {seq_y, seq_x};
                mem_wdata = CLEAR_VALUE;
            end
            IDLE: begin
                mem_we    = wr_acc && !wr_oor;
                mem_waddr = {wr_y, wr_x};
                mem_wdata = wr_data;
            end
            CAS_WR: begin
                mem_we    = cas_hit;
                mem_waddr = cas_addr;
                mem_wdata = cas_new_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [X_ADDR_WIDTH-1:0] px;
        logic [Y_ADDR_WIDTH-1:0] py;
        logic                    p_oor;
        logic [DATA_WIDTH-1:0]   q;

        assign px    = rd_x[i*X_ADDR_WIDTH +: X_ADDR_WIDTH];
        assign py    = rd_y[i*Y_ADDR_WIDTH +: Y_ADDR_WIDTH];
        assign p_oor = (32'(px) >= X_SIZE) || (32'(py) >= Y_SIZE);

        always_ff @(posedge clk) begin
            if (rst || busy || p_oor) q <= CLEAR_VALUE;
            else                      q <= mem[{py, px}];
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end

endmodule
